// File: rtl/branch_resolve_unit_if.sv
// Execute-lane branch results in, registered PHT update records and
// front-end recovery/flush signals out.
interface branch_resolve_unit_if #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int GH_WIDTH      = 10,
    parameter int PHT_IDX_WIDTH = 13,
    parameter int PHT_CNT_WIDTH = 2,
    parameter int STAT_WIDTH    = 16
);
    logic [ISSUE_WIDTH-1:0]   exValid;
    logic [ISSUE_WIDTH-1:0]   exCondBr;
    logic [ISSUE_WIDTH-1:0]   exIsAX;
    logic [ISSUE_WIDTH-1:0]   exPredTaken;
    logic [ISSUE_WIDTH-1:0]   exTaken;
    logic [ISSUE_WIDTH-1:0]   exTargetMispred;
    logic [PHT_IDX_WIDTH-1:0] exPhtIndex      [ISSUE_WIDTH];
    logic [PHT_CNT_WIDTH-1:0] exPhtPrevValue  [ISSUE_WIDTH];
    logic [GH_WIDTH-1:0]      exGlobalHistory [ISSUE_WIDTH];
    logic                     flushAck;

    logic [ISSUE_WIDTH-1:0]   brValid;
    logic [ISSUE_WIDTH-1:0]   brIsAX;
    logic [ISSUE_WIDTH-1:0]   brExecTaken;
    logic [ISSUE_WIDTH-1:0]   brMispred;
    logic [PHT_IDX_WIDTH-1:0] brPhtIndex     [ISSUE_WIDTH];
    logic [PHT_CNT_WIDTH-1:0] brPhtPrevValue [ISSUE_WIDTH];
    logic                     recoverBrHistory;
    logic [GH_WIDTH-1:0]      recoveredBrHistory;
    logic                     flushReq;
    logic [STAT_WIDTH-1:0]    squashCount;

    modport slave (
        input  exValid, exCondBr, exIsAX, exPredTaken, exTaken, exTargetMispred,
               exPhtIndex, exPhtPrevValue, exGlobalHistory, flushAck,
        output brValid, brIsAX, brExecTaken, brMispred, brPhtIndex, brPhtPrevValue,
               recoverBrHistory, recoveredBrHistory, flushReq, squashCount
    );

    modport master (
        output exValid, exCondBr, exIsAX, exPredTaken, exTaken, exTargetMispred,
               exPhtIndex, exPhtPrevValue, exGlobalHistory, flushAck,
        input  brValid, brIsAX, brExecTaken, brMispred, brPhtIndex, brPhtPrevValue,
               recoverBrHistory, recoveredBrHistory, flushReq, squashCount
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registers per-lane gshare PHT update records, raises history recovery on the
// oldest mispredict and squashes wrong-path results until the flush is acked.
module branch_resolve_unit #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int GH_WIDTH      = 10,
    parameter int PHT_IDX_WIDTH = 13,
    parameter int PHT_CNT_WIDTH = 2,
    parameter int STAT_WIDTH    = 16
) (
    input logic clk,
    input logic rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int LANE_CNT_W = $clog2(ISSUE_WIDTH + 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ISSUE_WIDTH-1:0]   br_valid_q, br_valid_d;
    logic [ISSUE_WIDTH-1:0]   br_is_ax_q, br_is_ax_d;
    logic [ISSUE_WIDTH-1:0]   br_exec_taken_q, br_exec_taken_d;
    logic [ISSUE_WIDTH-1:0]   br_mispred_q, br_mispred_d;
    logic [PHT_IDX_WIDTH-1:0] br_pht_index_q [ISSUE_WIDTH];
    logic [PHT_IDX_WIDTH-1:0] br_pht_index_d [ISSUE_WIDTH];
    logic [PHT_CNT_WIDTH-1:0] br_pht_prev_q  [ISSUE_WIDTH];
    logic [PHT_CNT_WIDTH-1:0] br_pht_prev_d  [ISSUE_WIDTH];
    logic                     recover_q, recover_d;
    logic [GH_WIDTH-1:0]      rec_hist_q, rec_hist_d;
    logic [STAT_WIDTH-1:0]    squash_cnt_q, squash_cnt_d;

    logic                     found;
    logic                     keep;
    logic                     lane_mis;
    logic [LANE_CNT_W-1:0]    squash_n;
    logic [STAT_WIDTH:0]      squash_sum;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        found        = 1'b0;
        keep         = 1'b0;
        lane_mis     = 1'b0;
        squash_n     = '0;
        recover_d    = 1'b0;
        rec_hist_d   = '0;

        // Lanes walk oldest-first; once a mispredict is found, younger lanes are wrong-path.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            lane_mis = bus.exValid[i] &
                       ((bus.exCondBr[i] & (bus.exPredTaken[i] ^ bus.exTaken[i])) |
                        (bus.exTaken[i] & bus.exTargetMispred[i]));
            keep = bus.exValid[i] & (state_q == ST_NORMAL) & ~found;

            br_valid_d[i]      = keep;
            br_is_ax_d[i]      = keep & bus.exIsAX[i];
            br_exec_taken_d[i] = keep & bus.exTaken[i];
            br_mispred_d[i]    = keep & lane_mis;
            br_pht_index_d[i]  = keep ? bus.exPhtIndex[i] : '0;
            br_pht_prev_d[i]   = keep ? bus.exPhtPrevValue[i] : '0;

            if (bus.exValid[i] && !keep) begin
                squash_n = squash_n + LANE_CNT_W'(1);
            end

            if (keep && lane_mis) begin
                found      = 1'b1;
                recover_d  = 1'b1;
                rec_hist_d = bus.exCondBr[i]
                           ? ((bus.exGlobalHistory[i] << 1) | GH_WIDTH'(bus.exTaken[i]))
                           : bus.exGlobalHistory[i];
            end
        end

        if (state_q == ST_NORMAL && found) begin
            state_d = ST_SQUASH;
        end else if (state_q == ST_SQUASH && bus.flushAck) begin
            state_d = ST_NORMAL;
        end

        squash_sum   = {1'b0, squash_cnt_q} + (STAT_WIDTH + 1)'(squash_n);
        squash_cnt_d = squash_sum[STAT_WIDTH] ? '1 : squash_sum[STAT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_NORMAL;
            br_valid_q      <= '0;
            br_is_ax_q      <= '0;
            br_exec_taken_q <= '0;
            br_mispred_q    <= '0;
            br_pht_index_q  <= '{default: '0};
            br_pht_prev_q   <= '{default: '0};
            recover_q       <= 1'b0;
            rec_hist_q      <= '0;
            squash_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            br_valid_q      <= br_valid_d;
            br_is_ax_q      <= br_is_ax_d;
            br_exec_taken_q <= br_exec_taken_d;
            br_mispred_q    <= br_mispred_d;
            br_pht_index_q  <= br_pht_index_d;
            br_pht_prev_q   <= br_pht_prev_d;
            recover_q       <= recover_d;
            rec_hist_q      <= rec_hist_d;
            squash_cnt_q    <= squash_cnt_d;
        end
    end

    // The flush request is exactly "in the squash window".
    assign bus.flushReq           = (state_q == ST_SQUASH);
    assign bus.brValid            = br_valid_q;
    assign bus.brIsAX             = br_is_ax_q;
    assign bus.brExecTaken        = br_exec_taken_q;
    assign bus.brMispred          = br_mispred_q;
    assign bus.brPhtIndex         = br_pht_index_q;
    assign bus.brPhtPrevValue     = br_pht_prev_q;
    assign bus.recoverBrHistory   = recover_q;
    assign bus.recoveredBrHistory = rec_hist_q;
    assign bus.squashCount        = squash_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if bus ();

    branch_resolve_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.exValid         = '0;
        bus.exCondBr        = '0;
        bus.exIsAX          = '0;
        bus.exPredTaken     = '0;
        bus.exTaken         = '0;
        bus.exTargetMispred = '0;
        for (int i = 0; i < 2; i++) begin
            bus.exPhtIndex[i]      = '0;
            bus.exPhtPrevValue[i]  = '0;
            bus.exGlobalHistory[i] = '0;
        end
    endtask

    task automatic set_lane(input int ln, input logic cond, input logic ax, input logic pred,
                            input logic taken, input logic tmis, input logic [12:0] idx,
                            input logic [1:0] prev, input logic [9:0] gh);
        bus.exValid[ln]         = 1'b1;
        bus.exCondBr[ln]        = cond;
        bus.exIsAX[ln]          = ax;
        bus.exPredTaken[ln]     = pred;
        bus.exTaken[ln]         = taken;
        bus.exTargetMispred[ln] = tmis;
        bus.exPhtIndex[ln]      = idx;
        bus.exPhtPrevValue[ln]  = prev;
        bus.exGlobalHistory[ln] = gh;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.flushAck = 1'b0;
        clear_lanes();
        step();
        step();
        check("rst_valid", 32'(bus.brValid), 32'h0);
        check("rst_flush", 32'(bus.flushReq), 32'h0);
        check("rst_sqcnt", 32'(bus.squashCount), 32'h0);
        check("rst_recover", 32'(bus.recoverBrHistory), 32'h0);
        rst_n = 1'b1;

        // Single correctly predicted conditional branch
        set_lane(0, 1, 0, 1, 1, 0, 13'h0A5, 2'd2, 10'h000);
        step();
        check("ok_valid", 32'(bus.brValid), 32'h1);
        check("ok_mispred", 32'(bus.brMispred), 32'h0);
        check("ok_index", 32'(bus.brPhtIndex[0]), 32'h0A5);
        check("ok_prev", 32'(bus.brPhtPrevValue[0]), 32'h2);
        check("ok_taken", 32'(bus.brExecTaken), 32'h1);
        check("ok_recover", 32'(bus.recoverBrHistory), 32'h0);
        check("ok_flush", 32'(bus.flushReq), 32'h0);

        // Direction mispredict, history 0x155 -> 0x2AA
        clear_lanes();
        set_lane(0, 1, 0, 1, 0, 0, 13'h011, 2'd1, 10'h155);
        step();
        check("dir_recover", 32'(bus.recoverBrHistory), 32'h1);
        check("dir_hist", 32'(bus.recoveredBrHistory), 32'h2AA);
        check("dir_mispred", 32'(bus.brMispred), 32'h1);
        check("dir_flush", 32'(bus.flushReq), 32'h1);
        clear_lanes();
        step();
        check("dir_pulse_end", 32'(bus.recoverBrHistory), 32'h0);
        check("dir_hist_zero", 32'(bus.recoveredBrHistory), 32'h0);
        check("dir_flush_hold", 32'(bus.flushReq), 32'h1);
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;
        check("dir_flush_drop", 32'(bus.flushReq), 32'h0);

        // Oldest lane mispredicts: younger lane squashed
        set_lane(0, 1, 0, 0, 1, 0, 13'h100, 2'd0, 10'h001);
        set_lane(1, 1, 0, 1, 1, 0, 13'h101, 2'd3, 10'h003);
        step();
        check("ord0_valid", 32'(bus.brValid), 32'h1);
        check("ord0_sqcnt", 32'(bus.squashCount), 32'h1);
        check("ord0_hist", 32'(bus.recoveredBrHistory), 32'h003);
        clear_lanes();
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;
        check("ord0_flush_drop", 32'(bus.flushReq), 32'h0);

        // Younger lane mispredicts: both records kept, recovery from lane 1
        set_lane(0, 1, 0, 0, 0, 0, 13'h200, 2'd1, 10'h0F0);
        set_lane(1, 1, 0, 1, 0, 0, 13'h201, 2'd2, 10'h201);
        step();
        check("ord1_valid", 32'(bus.brValid), 32'h3);
        check("ord1_mispred", 32'(bus.brMispred), 32'h2);
        check("ord1_hist", 32'(bus.recoveredBrHistory), 32'h002);
        check("ord1_index1", 32'(bus.brPhtIndex[1]), 32'h201);
        check("ord1_sqcnt", 32'(bus.squashCount), 32'h1);

        // Squash window: three cycles plus the ack cycle, two lanes each
        set_lane(0, 1, 0, 1, 0, 0, 13'h300, 2'd0, 10'h0AA);
        set_lane(1, 0, 0, 0, 1, 1, 13'h301, 2'd0, 10'h055);
        for (int c = 0; c < 3; c++) begin
            step();
            check("sq_valid", 32'(bus.brValid), 32'h0);
            check("sq_recover", 32'(bus.recoverBrHistory), 32'h0);
            check("sq_flush", 32'(bus.flushReq), 32'h1);
        end
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;
        check("sq_ack_valid", 32'(bus.brValid), 32'h0);
        check("sq_ack_recover", 32'(bus.recoverBrHistory), 32'h0);
        check("sq_ack_flush", 32'(bus.flushReq), 32'h0);
        check("sq_sqcnt", 32'(bus.squashCount), 32'd9);

        // Target mispredict on unconditional taken branch keeps history
        clear_lanes();
        set_lane(0, 0, 0, 0, 1, 1, 13'h3FF, 2'd3, 10'h3FF);
        step();
        check("tgt_hist", 32'(bus.recoveredBrHistory), 32'h3FF);
        check("tgt_mispred", 32'(bus.brMispred), 32'h1);
        check("tgt_recover", 32'(bus.recoverBrHistory), 32'h1);
        clear_lanes();
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;

        // Back-to-back event right after the ack
        set_lane(0, 1, 0, 0, 1, 0, 13'h050, 2'd1, 10'h200);
        step();
        check("b2b_recover", 32'(bus.recoverBrHistory), 32'h1);
        check("b2b_hist", 32'(bus.recoveredBrHistory), 32'h001);
        check("b2b_flush", 32'(bus.flushReq), 32'h1);
        clear_lanes();
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;

        // AX branch correctly predicted: flag passes through, flushAck in NORMAL ignored
        set_lane(0, 1, 1, 1, 1, 0, 13'h0C3, 2'd3, 10'h010);
        bus.flushAck = 1'b1;
        step();
        bus.flushAck = 1'b0;
        check("ax_valid", 32'(bus.brValid), 32'h1);
        check("ax_isax", 32'(bus.brIsAX), 32'h1);
        check("ax_mispred", 32'(bus.brMispred), 32'h0);
        check("ax_flush", 32'(bus.flushReq), 32'h0);
        check("ax_sqcnt", 32'(bus.squashCount), 32'd9);

        // Reset while in the squash window
        clear_lanes();
        set_lane(0, 1, 0, 1, 0, 0, 13'h007, 2'd0, 10'h001);
        step();
        check("rsq_flush_pre", 32'(bus.flushReq), 32'h1);
        set_lane(1, 1, 0, 1, 1, 0, 13'h008, 2'd0, 10'h001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rsq_flush", 32'(bus.flushReq), 32'h0);
        check("rsq_valid", 32'(bus.brValid), 32'h0);
        check("rsq_sqcnt", 32'(bus.squashCount), 32'h0);
        check("rsq_recover", 32'(bus.recoverBrHistory), 32'h0);
        clear_lanes();
        set_lane(1, 1, 0, 1, 1, 0, 13'h009, 2'd1, 10'h001);
        step();
        check("rsq_after_valid", 32'(bus.brValid), 32'h2);

        // Saturation: enter squash, then keep two lanes squashed every cycle
        clear_lanes();
        set_lane(0, 1, 0, 1, 0, 0, 13'h000, 2'd0, 10'h000);
        step();
        set_lane(1, 1, 0, 1, 1, 0, 13'h000, 2'd0, 10'h000);
        for (int c = 0; c < 32767; c++) begin
            @(posedge clk);
        end
        #1;
        check("sat_pre", 32'(bus.squashCount), 32'hFFFE);
        step();
        check("sat_hit", 32'(bus.squashCount), 32'hFFFF);
        step();
        check("sat_hold", 32'(bus.squashCount), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
